// File: rtl/ctrl_seq.sv
// Micro-sequencer for the 8-bit accumulator CPU: fetch/decode/execute state machine
// with combinational strobe decode. Define CTRL_ILLEGAL_TRAP_EN to trap opcodes 9-E.
module ctrl_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] ir,
   input  logic       zero,
   output logic       PCinc,
   output logic       PCload,
   output logic       IRload,
   output logic       MARload,
   output logic       MARsel,
   output logic       MemRd,
   output logic       MemWr,
   output logic       ACload,
   output logic       ACloadR,
   output logic [2:0] ALUop,
   output logic       halted,
   output logic       illegal,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_F1   = 3'd1,
      S_F2   = 3'd2,
      S_DEC  = 3'd3,
      S_E1   = 3'd4,
      S_E2   = 3'd5,
      S_HALT = 3'd6
   } state_t;

   state_t     r_state;
   logic [3:0] w_op;

   assign w_op  = ir[7:4];
   assign state = r_state;

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic r_illegal;
   assign illegal = r_illegal;
`else
   assign illegal = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
`ifdef CTRL_ILLEGAL_TRAP_EN
         r_illegal <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: if (start) r_state <= S_F1;
            S_F1:   r_state <= S_F2;
            S_F2:   r_state <= S_DEC;
            S_DEC: begin
               case (w_op)
                  4'h1, 4'h2, 4'h3, 4'h4, 4'h6: r_state <= S_E1;
                  4'hF:                         r_state <= S_HALT;
                  4'h0, 4'h5, 4'h7, 4'h8:       r_state <= S_F1;
                  default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                     r_state   <= S_HALT;
                     r_illegal <= 1'b1;
`else
                     r_state   <= S_F1;
`endif
                  end
               endcase
            end
            S_E1:   r_state <= (w_op == 4'h6) ? S_F1 : S_E2;
            S_E2:   r_state <= S_F1;
            S_HALT: r_state <= S_HALT;
            // Unused code 7 falls back to IDLE.
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      PCinc   = 1'b0;
      PCload  = 1'b0;
      IRload  = 1'b0;
      MARload = 1'b0;
      MARsel  = 1'b0;
      MemRd   = 1'b0;
      MemWr   = 1'b0;
      ACload  = 1'b0;
      ACloadR = 1'b0;
      ALUop   = 3'b000;
      halted  = 1'b0;
      case (r_state)
         S_F1: MARload = 1'b1;
         S_F2: begin
            MemRd  = 1'b1;
            IRload = 1'b1;
            PCinc  = 1'b1;
         end
         S_DEC: begin
            case (w_op)
               4'h1, 4'h2, 4'h3, 4'h4, 4'h6: begin
                  MARload = 1'b1;
                  MARsel  = 1'b1;
               end
               4'h5:    ACloadR = 1'b1;
               4'h7:    PCload  = 1'b1;
               4'h8:    PCload  = zero;
               default: ;
            endcase
         end
         S_E1: begin
            if (w_op == 4'h6) MemWr = 1'b1;
            else              MemRd = 1'b1;
         end
         S_E2: begin
            // ACloadR is never raised here, so ACload stays exclusive.
            ACload = 1'b1;
            case (w_op)
               4'h2:    ALUop = 3'b001;
               4'h3:    ALUop = 3'b010;
               4'h4:    ALUop = 3'b011;
               default: ALUop = 3'b000;
            endcase
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: expected per-cycle output vectors are queued per
// instruction and popped one per clock. Build with CTRL_ILLEGAL_TRAP_EN to cover the trap.
module tb_ctrl_seq;

   logic       clk, rst, start, zero;
   logic [7:0] ir;
   logic       PCinc, PCload, IRload, MARload, MARsel, MemRd, MemWr, ACload, ACloadR;
   logic [2:0] ALUop, state;
   logic       halted, illegal;

   int checks   = 0;
   int failures = 0;
   logic [16:0] exp_q[$];

   ctrl_seq dut (
      .clk(clk), .rst(rst), .start(start), .ir(ir), .zero(zero),
      .PCinc(PCinc), .PCload(PCload), .IRload(IRload), .MARload(MARload),
      .MARsel(MARsel), .MemRd(MemRd), .MemWr(MemWr), .ACload(ACload),
      .ACloadR(ACloadR), .ALUop(ALUop), .halted(halted), .illegal(illegal),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // strb: {PCinc,PCload,IRload,MARload,MARsel,MemRd,MemWr,ACload,ACloadR}
   function automatic logic [16:0] v(input logic [8:0] strb, input logic [2:0] alu,
                                     input logic h, input logic il, input logic [2:0] st);
      return {strb, alu, h, il, st};
   endfunction

   function automatic logic [16:0] observed();
      return {PCinc, PCload, IRload, MARload, MARsel, MemRd, MemWr, ACload, ACloadR,
              ALUop, halted, illegal, state};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_now(input string tag);
      logic [16:0] e;
      logic [16:0] o;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         o = observed();
         checks++;
         assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
         end
      end
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) begin
         tick();
         check_now(tag);
      end
   endtask

   // Queues the cycles after F1 for one instruction, ending in F1 or HALT.
   task automatic push_instr(input logic [7:0] op8, input logic z, input logic trap_en);
      logic [3:0] op;
      logic [2:0] alu;
      op = op8[7:4];
      exp_q.push_back(v(9'b101001000, 3'b000, 1'b0, 1'b0, 3'd2));
      case (op)
         4'h1, 4'h2, 4'h3, 4'h4: begin
            alu = (op == 4'h1) ? 3'b000 : (op == 4'h2) ? 3'b001 :
                  (op == 4'h3) ? 3'b010 : 3'b011;
            exp_q.push_back(v(9'b000110000, 3'b000, 1'b0, 1'b0, 3'd3));
            exp_q.push_back(v(9'b000001000, 3'b000, 1'b0, 1'b0, 3'd4));
            exp_q.push_back(v(9'b000000010, alu,    1'b0, 1'b0, 3'd5));
            exp_q.push_back(v(9'b000100000, 3'b000, 1'b0, 1'b0, 3'd1));
         end
         4'h6: begin
            exp_q.push_back(v(9'b000110000, 3'b000, 1'b0, 1'b0, 3'd3));
            exp_q.push_back(v(9'b000000100, 3'b000, 1'b0, 1'b0, 3'd4));
            exp_q.push_back(v(9'b000100000, 3'b000, 1'b0, 1'b0, 3'd1));
         end
         4'h5: begin
            exp_q.push_back(v(9'b000000001, 3'b000, 1'b0, 1'b0, 3'd3));
            exp_q.push_back(v(9'b000100000, 3'b000, 1'b0, 1'b0, 3'd1));
         end
         4'h7, 4'h8: begin
            exp_q.push_back(v({1'b0, (op == 4'h7) ? 1'b1 : z, 7'b0}, 3'b000, 1'b0, 1'b0, 3'd3));
            exp_q.push_back(v(9'b000100000, 3'b000, 1'b0, 1'b0, 3'd1));
         end
         4'hF: begin
            exp_q.push_back(v(9'b0, 3'b000, 1'b0, 1'b0, 3'd3));
            for (int i = 0; i < 3; i++) exp_q.push_back(v(9'b0, 3'b000, 1'b1, 1'b0, 3'd6));
         end
         4'h0: begin
            exp_q.push_back(v(9'b0, 3'b000, 1'b0, 1'b0, 3'd3));
            exp_q.push_back(v(9'b000100000, 3'b000, 1'b0, 1'b0, 3'd1));
         end
         default: begin
            exp_q.push_back(v(9'b0, 3'b000, 1'b0, 1'b0, 3'd3));
            if (trap_en) begin
               for (int i = 0; i < 3; i++) exp_q.push_back(v(9'b0, 3'b000, 1'b1, 1'b1, 3'd6));
            end else begin
               exp_q.push_back(v(9'b000100000, 3'b000, 1'b0, 1'b0, 3'd1));
            end
         end
      endcase
   endtask

   task automatic run_instr(input logic [7:0] op8, input logic z, input string tag);
      logic trap_en;
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap_en = 1'b1;
`else
      trap_en = 1'b0;
`endif
      ir   = op8;
      zero = z;
      push_instr(op8, z, trap_en);
      drain(tag);
   endtask

   // From IDLE: pulse start and check F1 on the following cycle.
   task automatic start_seq(input string tag);
      start = 1'b1;
      exp_q.push_back(v(9'b0, 3'b000, 1'b0, 1'b0, 3'd0));
      check_now({tag, "_idle"});
      tick();
      start = 1'b0;
      exp_q.push_back(v(9'b000100000, 3'b000, 1'b0, 1'b0, 3'd1));
      check_now({tag, "_f1"});
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      #1;
      exp_q.push_back(v(9'b0, 3'b000, 1'b0, 1'b0, 3'd0));
      check_now({tag, "_async"});
      tick();
      exp_q.push_back(v(9'b0, 3'b000, 1'b0, 1'b0, 3'd0));
      check_now({tag, "_held"});
      rst = 1'b1;
      tick();
      exp_q.push_back(v(9'b0, 3'b000, 1'b0, 1'b0, 3'd0));
      check_now({tag, "_idle"});
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; ir = 8'h00; zero = 1'b0;
      #3;
      exp_q.push_back(v(9'b0, 3'b000, 1'b0, 1'b0, 3'd0));
      check_now("reset");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         exp_q.push_back(v(9'b0, 3'b000, 1'b0, 1'b0, 3'd0));
         check_now("idle_hold");
      end
      start_seq("start");

      run_instr(8'h23, 1'b0, "add");
      run_instr(8'h50, 1'b0, "movr");
      run_instr(8'h85, 1'b0, "jz0");
      run_instr(8'h85, 1'b1, "jz1");
      run_instr(8'h64, 1'b1, "sta");
      run_instr(8'h00, 1'b1, "nop");
      run_instr(8'h7C, 1'b0, "jmp");
      run_instr(8'h19, 1'b1, "lda");
      run_instr(8'h32, 1'b0, "sub");
      run_instr(8'h4E, 1'b1, "and");
      start = 1'b1;
      run_instr(8'h21, 1'b0, "add_start_ignored");
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         run_instr({4'($urandom_range(0, 8)), 4'($urandom_range(0, 15))},
                   1'($urandom_range(0, 1)), "rand");
      end

      // Reset during E1 of an LDA.
      ir = 8'h1A;
      exp_q.push_back(v(9'b101001000, 3'b000, 1'b0, 1'b0, 3'd2));
      exp_q.push_back(v(9'b000110000, 3'b000, 1'b0, 1'b0, 3'd3));
      exp_q.push_back(v(9'b000001000, 3'b000, 1'b0, 1'b0, 3'd4));
      drain("lda_pre_rst");
      do_reset("rst_e1");
      start_seq("restart");

      run_instr(8'hA0, 1'b0, "illegal_a0");
`ifdef CTRL_ILLEGAL_TRAP_EN
      do_reset("rst_trap");
      start_seq("restart2");
`endif

      run_instr(8'hF0, 1'b0, "hlt");
      start = 1'b1;
      exp_q.push_back(v(9'b0, 3'b000, 1'b1, 1'b0, 3'd6));
      drain("hlt_start_ignored");
      start = 1'b0;
      do_reset("rst_halt");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
